multicycle_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I-subset datapath. It replaces the single-cycle combinational decode with an FSM that time-shares one memory port between instruction fetch and load/store. It drives PC, IR, register file, ALU and memory strobes step by step, waiting on a memory ready handshake. It also provides a retired-instruction counter and a memory-timeout error.

---
 rtl/multicycle_ctrl_fsm_if.sv | 26 ++
 rtl/multicycle_ctrl_fsm.sv | 112 +++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: datapath/memory control bundle between the sequencer (master) and the datapath (slave)
interface multicycle_ctrl_fsm_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read_en;
  logic       mem_write_en;
  logic       mem_to_reg;
  logic       reg_write_en;
  logic       alu_src;
  logic [1:0] alu_op;
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read_en, mem_write_en,
           mem_to_reg, reg_write_en, alu_src, alu_op
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read_en, mem_write_en,
           mem_to_reg, reg_write_en, alu_src, alu_op
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle RV32I-subset sequencer sharing one memory port, with retire counter and bus timeout.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt_req,
  multicycle_ctrl_fsm_if.master bus,
  output logic [2:0]           state,
  output logic                 retire,
  output logic [CNT_W-1:0]     instr_count,
  output logic                 bus_err
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_ILL = S_TRAP;
  localparam bit ILL_NOP = 1'b0;
`else
  localparam logic [2:0] S_ILL = S_FETCH;
  localparam bit ILL_NOP = 1'b1;
`endif
  logic [2:0]    state_nx;
  logic [6:0]    op;
  logic [WW-1:0] wait_cnt;
  logic          fresh, known, imm, halting, waiting, timeout, taken;
  assign known   = bus.opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};
  assign imm     = op inside {OP_I, OP_LD, OP_ST};
  assign taken   = op == OP_BR && bus.zero;
  // halt is only honoured on the first FETCH cycle, before any read is issued
  assign halting = state == S_FETCH && fresh && halt_req;
  assign waiting = (state == S_FETCH && !halting) || state == S_MEM;
  assign timeout = waiting && !bus.mem_ready && wait_cnt == WW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  state_nx = halting || timeout ? S_HALT : bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = known ? S_EXEC : S_ILL;
      S_EXEC:   state_nx = op inside {OP_R, OP_I} ? S_WB : op inside {OP_LD, OP_ST} ? S_MEM : S_FETCH;
      S_MEM:    state_nx = timeout ? S_HALT : !bus.mem_ready ? S_MEM : op == OP_LD ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = !halt_req && !bus_err ? S_FETCH : S_HALT;
      S_TRAP:   state_nx = S_TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op          <= '0;
      wait_cnt    <= '0;
      fresh       <= 1'b0;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      op          <= state == S_DECODE ? bus.opcode : op;
      wait_cnt    <= waiting && state_nx == state ? wait_cnt + 1'b1 : '0;
      fresh       <= state_nx == S_FETCH && state != S_FETCH;
      bus_err     <= bus_err | timeout;
      instr_count <= instr_count + CNT_W'(retire);
    end
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.pc_src       = 2'b00;
    bus.ir_write     = 1'b0;
    bus.iord         = 1'b0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.alu_src      = 1'b0;
    bus.alu_op       = 2'b00;
    retire           = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_read_en = !halting;
        bus.ir_write    = !halting && bus.mem_ready;
        bus.pc_write    = !halting && bus.mem_ready;
      end
      S_DECODE: retire = !known && ILL_NOP;
      S_EXEC: begin
        bus.alu_src      = imm;
        bus.alu_op       = op == OP_BR ? 2'b10 : imm ? 2'b01 : 2'b00;
        bus.pc_write     = op == OP_JAL || taken;
        bus.pc_src       = op == OP_JAL ? 2'b10 : taken ? 2'b01 : 2'b00;
        bus.reg_write_en = op == OP_JAL;
        retire           = op inside {OP_BR, OP_JAL};
      end
      S_MEM: begin
        bus.iord         = 1'b1;
        bus.alu_src      = 1'b1;
        bus.alu_op       = 2'b01;
        bus.mem_read_en  = op == OP_LD;
        bus.mem_write_en = op != OP_LD;
        retire           = op != OP_LD && bus.mem_ready;
      end
      S_WB: begin
        bus.reg_write_en = 1'b1;
        bus.mem_to_reg   = op == OP_LD;
        retire           = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: builds expected per-cycle traces from instruction-level phases and checks the sequencer.
module tb_multicycle_ctrl_fsm;
  localparam int MT = 4, CW = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;
  // expected strobe word: {pc_write, pc_src[1:0], ir_write, iord, rd, wr, mem_to_reg, reg_write, alu_src, alu_op[1:0], retire}
  localparam logic [12:0] PW = 13'h1000, PS_BR = 13'h0400, PS_J = 13'h0800, IRW = 13'h0200, IORD = 13'h0100,
                          MRD = 13'h0080, MWR = 13'h0040, M2R = 13'h0020, RW = 13'h0010, AS = 13'h0008,
                          AO_B = 13'h0004, AO_I = 13'h0002, RET = 13'h0001, NONE = 13'h0000;
  logic clk = 1'b0, rst_n = 1'b0, halt_req = 1'b0;
  logic [2:0] state;
  logic retire, bus_err;
  logic [CW-1:0] instr_count;
  multicycle_ctrl_fsm_if bus();
  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .bus(bus),
    .state(state), .retire(retire), .instr_count(instr_count), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic mr, hr, z;
    logic [6:0] op;
    logic [2:0] st;
    logic [12:0] sb;
    logic err;
  } step_t;
  step_t q[$];
  int total = 0, bad = 0, model_cnt = 0, nstep = 0;
  logic [6:0] cur_op = '0;
  logic err_m = 1'b0;
  logic [6:0] pool [7] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_BAD};
`ifdef CTRL_ILLEGAL_TRAP_EN
  int npool = 6;
`else
  int npool = 7;
`endif
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [12:0] obs();
    return {bus.pc_write, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read_en, bus.mem_write_en,
            bus.mem_to_reg, bus.reg_write_en, bus.alu_src, bus.alu_op, retire};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // opcode input is only meaningful from DECODE on; elsewhere it carries noise
  task automatic push(input logic mr, input logic hr, input logic z, input logic [2:0] st, input logic [12:0] s);
    step_t e;
    e.mr = mr; e.hr = hr; e.z = z; e.st = st; e.sb = s; e.err = err_m;
    e.op = st inside {3'd2, 3'd3, 3'd4, 3'd5} ? cur_op : 7'($urandom);
    q.push_back(e);
  endtask
  task automatic fetch(input int d);
    for (int i = 0; i <= d; i++)
      push(i == d, i == 0 ? 1'b0 : rb(), rb(), 3'd1, i == d ? MRD | IRW | PW : MRD);
  endtask
  task automatic instr(input logic [6:0] op, input int fd, input int md, input logic z);
    logic ld;
    ld = op == OP_LD;
    cur_op = op;
    fetch(fd);
    if (!(op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL})) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      push(rb(), rb(), rb(), 3'd2, NONE);
      for (int i = 0; i < 4; i++) push(rb(), rb(), rb(), 3'd7, NONE);
`else
      push(rb(), rb(), rb(), 3'd2, RET);
`endif
      return;
    end
    push(rb(), rb(), rb(), 3'd2, NONE);
    case (op)
      OP_R:               push(rb(), rb(), rb(), 3'd3, NONE);
      OP_I, OP_LD, OP_ST: push(rb(), rb(), rb(), 3'd3, AS | AO_I);
      OP_BR:              push(rb(), rb(), z, 3'd3, AO_B | RET | (z ? PW | PS_BR : NONE));
      default:            push(rb(), rb(), rb(), 3'd3, PW | PS_J | RW | RET);
    endcase
    if (op inside {OP_LD, OP_ST})
      for (int i = 0; i <= md; i++)
        push(i == md, rb(), rb(), 3'd4, IORD | AS | AO_I | (ld ? MRD : MWR) | (i == md && !ld ? RET : NONE));
    if (op inside {OP_R, OP_I, OP_LD}) push(rb(), rb(), rb(), 3'd5, RW | RET | (ld ? M2R : NONE));
  endtask
  task automatic halt_park(input int k);
    push(rb(), 1'b1, rb(), 3'd1, NONE);
    for (int i = 0; i < k; i++) push(rb(), 1'b1, rb(), 3'd6, NONE);
    push(rb(), 1'b0, rb(), 3'd6, NONE);
  endtask
  task automatic run();
    step_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      bus.mem_ready = e.mr; halt_req = e.hr; bus.zero = e.z; bus.opcode = e.op;
      #1;
      chk($sformatf("state@%0d", nstep), 32'(state), 32'(e.st));
      chk($sformatf("strobes@%0d", nstep), 32'(obs()), 32'(e.sb));
      chk($sformatf("count@%0d", nstep), 32'(instr_count), 32'(model_cnt % (1 << CW)));
      chk($sformatf("bus_err@%0d", nstep), 32'(bus_err), 32'(e.err));
      if (e.sb[0]) model_cnt++;
      nstep++;
      @(negedge clk);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_strobes"}, 32'(obs()), 0);
    chk({tag, "_count"}, 32'(instr_count), 0);
    chk({tag, "_bus_err"}, 32'(bus_err), 0);
    model_cnt = 0;
    err_m = 1'b0;
  endtask
  initial begin
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;
    push(rb(), rb(), rb(), 3'd0, NONE);
    instr(OP_R, 0, 0, 1'b0);
    instr(OP_LD, 3, 3, 1'b0);
    instr(OP_BR, 0, 0, 1'b1);
    instr(OP_BR, 1, 0, 1'b0);
    instr(OP_JAL, 0, 0, 1'b0);
    instr(OP_I, 2, 0, 1'b0);
    instr(OP_ST, 1, 2, 1'b0);
    halt_park(2);
    instr(OP_R, 0, 0, 1'b0);
    run();
    repeat (40) begin
      if ($urandom_range(0, 5) == 0) halt_park($urandom_range(0, 2));
      instr(pool[$urandom_range(0, npool - 1)], $urandom_range(0, MT - 1), $urandom_range(0, MT - 1), rb());
    end
    run();
    // reset while a store is waiting on memory
    cur_op = OP_ST;
    fetch(0);
    push(rb(), rb(), rb(), 3'd2, NONE);
    push(rb(), rb(), rb(), 3'd3, AS | AO_I);
    for (int i = 0; i < 2; i++) push(1'b0, rb(), rb(), 3'd4, IORD | AS | AO_I | MWR);
    run();
    bus.mem_ready = 1'b0;
    #1;
    chk("pre_rst_wr", 32'(bus.mem_write_en), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    push(rb(), rb(), rb(), 3'd0, NONE);
    cur_op = OP_ST;
    fetch(1);
    push(rb(), rb(), rb(), 3'd2, NONE);
    push(rb(), rb(), rb(), 3'd3, AS | AO_I);
    for (int i = 0; i < MT; i++) push(1'b0, rb(), rb(), 3'd4, IORD | AS | AO_I | MWR);
    err_m = 1'b1;
    for (int i = 0; i < 4; i++) push(rb(), 1'b0, rb(), 3'd6, NONE);
    run();
    rst_n = 1'b0;
    #1;
    chk_reset("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    push(rb(), rb(), rb(), 3'd0, NONE);
`ifdef CTRL_ILLEGAL_TRAP_EN
    instr(OP_R, 0, 0, 1'b0);
    instr(OP_BAD, 0, 0, 1'b0);
    run();
    chk("trap_count", 32'(instr_count), 1);
`else
    for (int i = 0; i < 16; i++) instr(OP_BAD, $urandom_range(0, 1), 0, 1'b0);
    run();
    chk("wrap_count", 32'(instr_count), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
